sar_adc_ctrl: RTL and testbench
===============================

# sar_adc_ctrl

Successive-approximation ADC controller that reads an analog signal back into the FPGA through the existing 8-bit PMOD R2R ladder plus one external comparator. It drives trial codes onto the R2R DAC pins, samples the comparator after a settle interval, and binary-searches each bit MSB-first. It produces one 8-bit sample per conversion at a programmable sample rate. It is the capture-side counterpart to the LUT waveform generators and feeds the synth's input and modulation path.

## Interface
- SETTLE_CYCLES, 16: clocks DAC output is held before comparator is sampled; minimum 3, which covers the 2-flop sync.
- SAMPLE_PERIOD, 2083: clocks between conversion-start ticks; 48 kHz at 100 MHz.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  enables the sample timer and conversion starts.
- cmp  in  1  asynchronous comparator output; 1 means analog input >= DAC voltage.
- dac  out  8  trial code to the R2R PMOD pins.
- sample  out  8  last completed result.
- valid  out  1  one-cycle pulse when sample updates.
- busy  out  1  high while a conversion is in progress.
- overrun  out  1  one-cycle pulse when a tick is dropped.

## Operation
- Reset (async, rst_n low): all outputs 0; state IDLE; timer 0; sync flops 0; result register 0; averaging history 0.
- Sample timer:
  - Counts 0..SAMPLE_PERIOD-1 while en=1; wraps to 0.
  - tick = (count == SAMPLE_PERIOD-1).
  - en=0 clears the count to 0.
- cmp passes through a 2-flop synchronizer (cmp_s) before use.
- State machine: IDLE, SETTLE, DECIDE.
  - IDLE, tick: result <= 0; dac <= 8'h80; bit index <= 7; settle count <= 0; busy <= 1; go to SETTLE.
  - SETTLE: increment settle count; when it reaches SETTLE_CYCLES-1, go to DECIDE.
  - DECIDE, bit k: result[k] <= cmp_s.
    - If k>0: dac <= new result with bit k-1 set; k <= k-1; go to SETTLE.
    - If k==0: sample <= final result (or the average, see Configuration); valid <= 1 for one cycle; dac <= 0; busy <= 0; go to IDLE.
- Idle dac value is 0x00.
- Falling en mid-conversion does not abort. The current conversion completes and outputs; no further starts occur.
- A tick while busy=1 is dropped and overrun pulses for one cycle. The next conversion starts at the next tick.
- A tick coincident with the DECIDE k==0 edge counts as busy: it is dropped and overrun pulses.
- Reset mid-conversion aborts immediately with reset values and no valid pulse.

## Timing
- Each bit occupies SETTLE_CYCLES+1 cycles.
- Latency from the tick edge to valid high is 8*(SETTLE_CYCLES+1) cycles. With SETTLE_CYCLES=3 this is 32 cycles.
- cmp must be stable at least 2 cycles before DECIDE. This is guaranteed by SETTLE_CYCLES >= 3 for an ideal comparator.
- sample holds its value until the next valid.
- busy drops on the same edge that valid rises.

## Configuration
- SAR_ADC_AVG_EN defined: sample = (sum of the last 4 conversion results) >> 2, truncating.
  - History is a 4-entry shift register plus a 10-bit running sum, zero at reset.
  - The first three outputs after reset include zeros.
  - Same latency.
- Undefined: sample = raw conversion result; no history logic.

## Structure
- Package sar_adc_pkg:
  - state enum (IDLE, SETTLE, DECIDE);
  - DAC_W = 8;
  - AVG_DEPTH = 4;
  - SUM_W = 10.
- Sub-module cmp_sync: 2-flop synchronizer with async active-low reset to 0, instantiated for cmp.

## Test plan
- Comparator model with Vin code 0xA5, SETTLE_CYCLES=3 -> dac sequence 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5; valid 32 cycles after tick; sample=0xA5.
- cmp tied 1 -> sample 0xFF; cmp tied 0 -> sample 0x00, dac returns to 0x00 after each conversion.
- SAMPLE_PERIOD=20, SETTLE_CYCLES=3 -> every other tick is dropped with an overrun pulse; valid pulses every 40 cycles.
- en deasserted at cycle 10 of a conversion -> conversion completes with valid; no further busy.
- rst_n low at cycle 15 of a conversion -> dac, sample, busy, valid all 0 immediately; no valid pulse after release until the next tick plus 32 cycles.
- With SAR_ADC_AVG_EN, Vin codes 0x10, 0x20, 0x30, 0x40 on successive conversions from reset -> samples 0x04, 0x0C, 0x18, 0x28.

Source files
------------

// File: rtl/sar_adc_pkg.sv
// Shared types and sizes for the SAR ADC controller (R2R ladder + external comparator).
package sar_adc_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, DECIDE} state_e;

  localparam int DAC_W     = 8;
  localparam int AVG_DEPTH = 4;
  localparam int SUM_W     = 10;
endpackage

// File: rtl/sar_adc_ctrl_cmp_sync.sv
// Two-flop synchronizer bringing the asynchronous comparator output into the clk domain.
module cmp_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: binary-searches an 8-bit code MSB-first on the R2R DAC.
// Define SAR_ADC_AVG_EN to output a 4-deep moving average instead of the raw conversion result.
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLE_PERIOD = 2083
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cmp,
  output logic [DAC_W-1:0] dac,
  output logic [DAC_W-1:0] sample,
  output logic             valid,
  output logic             busy,
  output logic             overrun
);
  localparam int TMR_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int BIT_W = $clog2(DAC_W);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_PERIOD - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [SET_W-1:0] set_q, set_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [DAC_W-1:0] res_q, res_d;
  logic [DAC_W-1:0] dac_q, dac_d;
  logic [DAC_W-1:0] sample_q, sample_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             ovr_q, ovr_d;
  logic             tick;
  logic             cmp_s;
  logic [DAC_W-1:0] res_new;
  logic [DAC_W-1:0] result_out;

  cmp_sync u_cmp_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (cmp),
    .q_o   (cmp_s)
  );

  assign tick  = en && (tmr_q == TMR_LAST);
  assign tmr_d = (!en || tick) ? '0 : tmr_q + TMR_W'(1);

  // Bits below the one being decided are still zero, so OR-ing in the decision is enough.
  assign res_new = res_q | (DAC_W'(cmp_s) << bit_q);

`ifdef SAR_ADC_AVG_EN
  logic [DAC_W-1:0] hist_q [AVG_DEPTH];
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             done;

  assign done       = (state_q == DECIDE) && (bit_q == '0);
  assign sum_d      = sum_q + SUM_W'(res_new) - SUM_W'(hist_q[AVG_DEPTH-1]);
  assign result_out = sum_d[SUM_W-1 -: DAC_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      for (int i = 0; i < AVG_DEPTH; i++) hist_q[i] <= '0;
    end else if (done) begin
      sum_q     <= sum_d;
      hist_q[0] <= res_new;
      for (int i = 1; i < AVG_DEPTH; i++) hist_q[i] <= hist_q[i-1];
    end
  end
`else
  assign result_out = res_new;
`endif

  always_comb begin
    state_d  = state_q;
    set_d    = set_q;
    bit_d    = bit_q;
    res_d    = res_q;
    dac_d    = dac_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;
    // busy is still high on the final DECIDE edge, so a coincident tick is dropped too.
    ovr_d    = tick && busy_q;
    case (state_q)
      IDLE: begin
        if (tick) begin
          res_d   = '0;
          dac_d   = DAC_W'(1) << (DAC_W - 1);
          bit_d   = BIT_W'(DAC_W - 1);
          set_d   = '0;
          busy_d  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (set_q == SET_LAST) state_d = DECIDE;
        else                   set_d   = set_q + SET_W'(1);
      end
      DECIDE: begin
        res_d = res_new;
        set_d = '0;
        if (bit_q != '0) begin
          dac_d   = res_new | (DAC_W'(1) << (bit_q - BIT_W'(1)));
          bit_d   = bit_q - BIT_W'(1);
          state_d = SETTLE;
        end else begin
          sample_d = result_out;
          valid_d  = 1'b1;
          dac_d    = '0;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      set_q    <= '0;
      bit_q    <= '0;
      res_q    <= '0;
      dac_q    <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      set_q    <= set_d;
      bit_q    <= bit_d;
      res_q    <= res_d;
      dac_q    <= dac_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      ovr_q    <= ovr_d;
    end
  end

  assign dac     = dac_q;
  assign sample  = sample_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign overrun = ovr_q;
endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl: ideal comparator, event-level reference model, directed and random stimulus.
module tb_sar_adc_ctrl;
  localparam int S    = 3;
  localparam int P    = 20;
  localparam int CONV = 8 * (S + 1);

  logic       clk = 1'b0;
  logic       rst_n, en, cmp;
  logic [7:0] dac, sample;
  logic       valid, busy, overrun;
  logic [7:0] vin;
  int         mode;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // mode 1: comparator stuck high, mode 2: stuck low, otherwise ideal comparator against vin.
  assign cmp = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : (vin >= dac);

  sar_adc_ctrl #(.SETTLE_CYCLES(S), .SAMPLE_PERIOD(P)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .cmp     (cmp),
    .dac     (dac),
    .sample  (sample),
    .valid   (valid),
    .busy    (busy),
    .overrun (overrun)
  );

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which conversion is running, how far along, what it will return.
  int         m_cnt, m_age;
  bit         m_active, m_valid, m_ovr, m_tick;
  logic [7:0] m_res, m_sample;
  int         hist [4];

  function automatic logic [7:0] trial(input logic [7:0] r, input int j);
    logic [7:0] keep, one;
    keep = 8'hFF;
    keep = keep << (8 - j);
    one  = 8'h80;
    one  = one >> j;
    return (r & keep) | one;
  endfunction

  function automatic logic [7:0] model_out(input logic [7:0] r);
`ifdef SAR_ADC_AVG_EN
    int sum;
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = int'(r);
    sum = hist[0] + hist[1] + hist[2] + hist[3];
    return 8'(sum / 4);
`else
    return r;
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_dac", int'(dac), 0);
      check("rst_sample", int'(sample), 0);
      check("rst_valid", int'(valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_overrun", int'(overrun), 0);
      m_cnt = 0; m_age = 0; m_active = 0; m_valid = 0; m_ovr = 0;
      m_res = 8'h00; m_sample = 8'h00;
      for (int i = 0; i < 4; i++) hist[i] = 0;
    end else begin
      check("dac", int'(dac), m_active ? int'(trial(m_res, m_age / (S + 1))) : 0);
      check("sample", int'(sample), int'(m_sample));
      check("valid", int'(valid), int'(m_valid));
      check("busy", int'(busy), int'(m_active));
      check("overrun", int'(overrun), int'(m_ovr));
      m_tick  = en && (m_cnt == P - 1);
      m_cnt   = (!en || m_tick) ? 0 : m_cnt + 1;
      m_valid = 0;
      m_ovr   = 0;
      if (m_active) begin
        m_ovr = m_tick;
        m_age++;
        if (m_age == CONV) begin
          m_active = 0;
          m_valid  = 1;
          m_sample = model_out(m_res);
        end
      end else if (m_tick) begin
        m_active = 1;
        m_age    = 0;
        m_res    = (mode == 1) ? 8'hFF : (mode == 2) ? 8'h00 : vin;
      end
    end
  end

  task automatic wait_busy();
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk); #1;
      if (busy) ok = 1;
    end
    check("busy_rise_timeout", int'(ok), 1);
  endtask

  task automatic wait_valid(output int cycles, output int ovrs);
    bit ok = 0;
    cycles = 0;
    ovrs   = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk); #1;
      cycles++;
      if (overrun) ovrs++;
      if (valid) ok = 1;
    end
    check("valid_timeout", int'(ok), 1);
  endtask

  logic [7:0] seq_a5 [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
  logic [7:0] avg_in [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
  logic [7:0] avg_ex [4] = '{8'h04, 8'h0C, 8'h18, 8'h28};

  initial begin
    int cyc, ovr, busy_hi;
    rst_n = 1'b0; en = 1'b0; vin = 8'h00; mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dac", int'(dac), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_sample", int'(sample), 0);
    rst_n = 1'b1;

`ifdef SAR_ADC_AVG_EN
    vin = avg_in[0];
    en  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_valid(cyc, ovr);
      check("avg_sample", int'(sample), int'(avg_ex[i]));
      if (i < 3) vin = avg_in[i+1];
    end
    en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
`endif

    // Vin 0xA5: trial codes, latency and result.
    vin = 8'hA5;
    en  = 1'b1;
    wait_busy();
    check("a5_trial0", int'(dac), int'(seq_a5[0]));
    for (int j = 1; j < 8; j++) begin
      repeat (S + 1) @(posedge clk);
      #1;
      check("a5_trial", int'(dac), int'(seq_a5[j]));
    end
    wait_valid(cyc, ovr);
    check("a5_latency", 7 * (S + 1) + cyc, 32);
`ifndef SAR_ADC_AVG_EN
    check("a5_sample", int'(sample), 8'hA5);
`endif

    // Comparator stuck high; every other tick dropped while busy.
    mode = 1;
    wait_valid(cyc, ovr);
    check("valid_interval", cyc, 40);
    check("overruns_per_interval", ovr, 1);
    check("dac_idle_after_ff", int'(dac), 0);
`ifndef SAR_ADC_AVG_EN
    check("tied1_sample", int'(sample), 8'hFF);
`endif
    mode = 2;
    wait_valid(cyc, ovr);
    check("dac_idle_after_00", int'(dac), 0);
`ifndef SAR_ADC_AVG_EN
    check("tied0_sample", int'(sample), 8'h00);
`endif
    mode = 0;
    vin  = 8'h3C;

    // en falls mid-conversion: finishes, then stays idle.
    wait_busy();
    repeat (10) @(posedge clk);
    #1;
    en = 1'b0;
    wait_valid(cyc, ovr);
`ifndef SAR_ADC_AVG_EN
    check("en_drop_sample", int'(sample), 8'h3C);
`endif
    busy_hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (busy) busy_hi++;
    end
    check("no_busy_after_en_drop", busy_hi, 0);

    // Reset mid-conversion.
    vin = 8'h5A;
    en  = 1'b1;
    wait_busy();
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_dac", int'(dac), 0);
    check("midrst_sample", int'(sample), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_valid", int'(valid), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_busy();
    wait_valid(cyc, ovr);
    check("post_reset_latency", cyc, 32);

    // Random vin and en activity; vin only moves while no conversion is running.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (!m_active && $urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 5))
          0:       vin = 8'h00;
          1:       vin = 8'hFF;
          default: vin = 8'($urandom);
        endcase
      end
      if ($urandom_range(0, 99) == 0) en = ~en;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
